beat_sequencer: RTL and testbench
=================================

Name: beat_sequencer

Overview:
- Timing generator for the hardwired controller: issues the one-hot beat signals w1/w2/w3 that make up each machine cycle.
- Shortens the machine cycle on `short`, extends it on `long`, and halts on `stop`.
- Restarts from the front-panel start button `qd`; supports single-step.
- Sits between the panel/clock source and the controller; the controller's short/long/stop outputs feed back into it.

Parameters:
- CYCLE_W, 8: width of the machine-cycle counter `cycles`.
- AUTO_START, 0: 1 means leave reset directly into W1 without a qd press; 0 means leave reset into IDLE.

Ports:
- t3  in  1  clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- qd  in  1  start pushbutton, debounced level; a rising edge starts execution.
- sstep  in  1  single-step mode; 1 means halt after every machine cycle.
- short  in  1  from controller; end the machine cycle after W1.
- long  in  1  from controller; extend the machine cycle to W3.
- stop  in  1  from controller; halt at the end of the current machine cycle.
- w1  out  1  beat 1 active.
- w2  out  1  beat 2 active.
- w3  out  1  beat 3 active.
- running  out  1  1 while any beat is active.
- cycles  out  CYCLE_W  completed machine cycles, modulo 2^CYCLE_W.

Behaviour:
- States: IDLE, W1, W2, W3.
  - Outputs are registered and decoded straight from state: w1=(W1), w2=(W2), w3=(W3), running=~IDLE.
  - At most one of w1/w2/w3 is ever high.
- Reset (clr=1, asynchronous):
  - state=IDLE, or W1 if AUTO_START=1.
  - w1/w2/w3=0, except w1=1 when AUTO_START=1.
  - running matches the reset state; cycles=0; qd_d=0; stop_seen=0.
- qd edge detect:
  - qd_d is registered qd every cycle; start = qd & ~qd_d.
  - start is acted on only in IDLE; it is ignored in W1/W2/W3.
  - Holding qd high produces exactly one start.
- IDLE: on start, go to W1 the next cycle; otherwise stay.
- W1: if short=1, end the cycle (EOC); else go to W2.
- W2: if long=1, go to W3; else EOC.
  - long is ignored in W1; short is ignored in W2/W3.
  - short=long=1 in W1 gives EOC (short wins).
- W3: always EOC.
- stop_seen:
  - Set on any beat (W1/W2/W3) where stop=1.
  - Cleared at EOC.
  - stop never truncates the current machine cycle.
- EOC rules:
  - cycles increments by 1, wrapping from all-ones to 0.
  - Next state is IDLE if (stop_seen | stop | sstep); otherwise W1.
  - Back-to-back machine cycles have no idle gap: W1 follows the final beat on the very next edge.
- Machine-cycle lengths: short gives 1 clock, normal 2, long 3.
- Changing sstep mid-cycle takes effect at the next EOC only.
- clr asserted mid-cycle: immediate return to the reset state, and the partial cycle is not counted.

Test Plan:
- Reset with AUTO_START=0 -> w1=w2=w3=0, running=0, cycles=0; qd rising edge -> w1=1 on the next edge; with short=long=0 the beat sequence is W1,W2,W1,W2…; cycles increments on each W2 exit.
- With running, drive short=1 in W1 and long=1 in W2 of alternating cycles -> beat sequence W1 | W1,W2,W3 | …; cycles counts 1 per machine cycle; short=long=1 in W1 gives a 1-clock cycle.
- Pulse stop=1 for one clock during W1 of a normal cycle -> W2 still occurs, then IDLE, running=0; a new qd edge resumes at W1; holding qd high gives only one start.
- sstep=1 -> each qd press yields exactly one machine cycle and cycles+1; qd pressed while running is ignored.
- Preload 255 cycles with CYCLE_W=8 -> the next EOC gives cycles=0.
- Assert clr during W2 -> outputs drop asynchronously, cycles=0, state IDLE; with AUTO_START=1, release of clr gives w1=1.

Source files
------------

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - beat timing generator (W1/W2/W3) for the hardwired controller
module beat_sequencer #(
    parameter int CYCLE_W    = 8,
    parameter bit AUTO_START = 1'b0
) (
    input  logic               t3,
    input  logic               clr,
    input  logic               qd,
    input  logic               sstep,
    input  logic               short,
    input  logic               long,
    input  logic               stop,
    output logic               w1,
    output logic               w2,
    output logic               w3,
    output logic               running,
    output logic [CYCLE_W-1:0] cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_W1   = 2'd1,
        S_W2   = 2'd2,
        S_W3   = 2'd3
    } state_t;

    localparam state_t RESET_STATE = AUTO_START ? S_W1 : S_IDLE;

    state_t             state;
    state_t             state_nx;
    logic               qd_d;
    logic               stop_seen;
    logic               stop_seen_nx;
    logic               eoc;
    logic               start;
    logic [CYCLE_W-1:0] cycles_nx;

    assign start = qd & ~qd_d;

    always_ff @(posedge t3 or posedge clr) begin
        if (clr) begin
            state     <= RESET_STATE;
            cycles    <= '0;
            qd_d      <= 1'b0;
            stop_seen <= 1'b0;
        end else begin
            state     <= state_nx;
            cycles    <= cycles_nx;
            qd_d      <= qd;
            stop_seen <= stop_seen_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        eoc          = 1'b0;
        stop_seen_nx = stop_seen;
        cycles_nx    = cycles;
        case (state)
            S_IDLE: if (start) state_nx = S_W1;
            S_W1:   if (short) eoc = 1'b1; else state_nx = S_W2;
            S_W2:   if (long) state_nx = S_W3; else eoc = 1'b1;
            S_W3:   eoc = 1'b1;
            default: state_nx = S_IDLE;
        endcase
        if (state != S_IDLE && stop) stop_seen_nx = 1'b1;
        // A pending halt is sampled only at end of cycle; stop never truncates a cycle.
        if (eoc) begin
            stop_seen_nx = 1'b0;
            cycles_nx    = cycles + CYCLE_W'(1);
            state_nx     = (stop_seen | stop | sstep) ? S_IDLE : S_W1;
        end
    end

    assign w1      = (state == S_W1);
    assign w2      = (state == S_W2);
    assign w3      = (state == S_W3);
    assign running = (state != S_IDLE);

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - directed self-checking bench for beat_sequencer
module tb_beat_sequencer;

    logic       t3 = 1'b0;
    logic       clr, qd, sstep, short, long, stop;
    logic       w1, w2, w3, running;
    logic [7:0] cycles;
    logic       a_w1, a_w2, a_w3, a_running;
    logic [7:0] a_cycles;
    int         tests = 0;
    int         fails = 0;

    beat_sequencer #(.CYCLE_W(8), .AUTO_START(1'b0)) dut (
        .t3(t3), .clr(clr), .qd(qd), .sstep(sstep), .short(short), .long(long), .stop(stop),
        .w1(w1), .w2(w2), .w3(w3), .running(running), .cycles(cycles)
    );

    beat_sequencer #(.CYCLE_W(8), .AUTO_START(1'b1)) dut_a (
        .t3(t3), .clr(clr), .qd(qd), .sstep(sstep), .short(short), .long(long), .stop(stop),
        .w1(a_w1), .w2(a_w2), .w3(a_w3), .running(a_running), .cycles(a_cycles)
    );

    always #5 t3 = ~t3;

    task automatic tick();
        @(posedge t3);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // beats packed as {running, w1, w2, w3}
    task automatic check_beats(input string tag, input logic [3:0] expected, input logic [7:0] exp_cycles);
        check(tag, {28'd0, running, w1, w2, w3}, {28'd0, expected});
        check({tag, "_cycles"}, {24'd0, cycles}, {24'd0, exp_cycles});
    endtask

    initial begin
        clr = 1'b1; qd = 1'b0; sstep = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
        repeat (2) tick();
        check_beats("reset", 4'b0000, 8'd0);
        check("auto_reset_w1", {31'd0, a_w1}, 32'd1);
        clr = 1'b0;
        tick();
        check_beats("idle_no_start", 4'b0000, 8'd0);

        // normal cycles W1,W2,W1,W2
        qd = 1'b1;
        tick(); check_beats("start_w1", 4'b1100, 8'd0);
        tick(); check_beats("norm_w2", 4'b1010, 8'd0);
        tick(); check_beats("norm_w1b", 4'b1100, 8'd1);
        tick(); check_beats("norm_w2b", 4'b1010, 8'd1);
        tick(); check_beats("norm_w1c", 4'b1100, 8'd2);

        // short, then long
        short = 1'b1;
        tick(); check_beats("short_w1", 4'b1100, 8'd3);
        short = 1'b0;
        tick(); check_beats("long_w2", 4'b1010, 8'd3);
        long = 1'b1;
        tick(); check_beats("long_w3", 4'b1001, 8'd3);
        long = 1'b0;
        tick(); check_beats("long_end", 4'b1100, 8'd4);
        short = 1'b1; long = 1'b1;
        tick(); check_beats("short_wins", 4'b1100, 8'd5);
        short = 1'b0; long = 1'b0;

        // stop pulse in W1 does not truncate the cycle
        stop = 1'b1;
        tick(); check_beats("stop_w2", 4'b1010, 8'd5);
        stop = 1'b0;
        tick(); check_beats("stop_idle", 4'b0000, 8'd6);
        tick(); check_beats("qd_held_no_start", 4'b0000, 8'd6);
        qd = 1'b0;
        tick();
        qd = 1'b1;
        tick(); check_beats("restart_w1", 4'b1100, 8'd6);

        // single-step
        sstep = 1'b1;
        tick(); check_beats("sstep_w2", 4'b1010, 8'd6);
        tick(); check_beats("sstep_idle", 4'b0000, 8'd7);
        qd = 1'b0; tick();
        qd = 1'b1;
        tick(); check_beats("sstep_w1", 4'b1100, 8'd7);
        qd = 1'b0; tick();
        qd = 1'b1;
        tick(); check_beats("qd_ignored_running", 4'b0000, 8'd8);
        tick(); check_beats("sstep_stays_idle", 4'b0000, 8'd8);

        // counter wrap using 1-clock cycles
        sstep = 1'b0; qd = 1'b0; tick();
        qd = 1'b1;
        tick(); check_beats("wrap_start", 4'b1100, 8'd8);
        short = 1'b1;
        repeat (247) tick();
        check_beats("at_255", 4'b1100, 8'd255);
        tick(); check_beats("wrap_0", 4'b1100, 8'd0);
        short = 1'b0;
        tick(); check_beats("pre_clr_w2", 4'b1010, 8'd0);
        tick(); check_beats("pre_clr_w1", 4'b1100, 8'd1);
        tick(); check_beats("pre_clr_w2b", 4'b1010, 8'd1);

        // asynchronous clear mid-W2
        #2 clr = 1'b1;
        #1;
        check_beats("async_clr", 4'b0000, 8'd0);
        check("auto_clr_w1", {30'd0, a_w1, a_running}, 32'd3);
        clr = 1'b0;
        #1;
        check("auto_release_w1", {31'd0, a_w1}, 32'd1);
        qd = 1'b0;
        tick(); check_beats("post_clr_idle", 4'b0000, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
